rx_bit_timer: RTL
=================

# rx_bit_timer

Parametrised oversampling timing generator for the UART receive path. Once a start edge is detected, it counts prescale clock edges per bit and bits per frame, and emits mid-bit sample strobes, per-bit done pulses and an end-of-frame pulse. The frame length is configured at run time from the data width, parity enable and stop-bit count. The block sits between the start-edge detector and the data sampler, deserializer and parity/stop checkers.

## Interface
Parameters:
- PRESCALE_W, 6, width of `prescale` and `edge_cnt`.
- BIT_CNT_W, 4, width of `bit_cnt`. Must hold the maximum frame length of 13 bits.

Ports:
- clk  in  1  receiver oversampling clock.
- rst  in  1  asynchronous, active-low reset.
- prescale  in  PRESCALE_W  oversampling ratio P. Latched at frame start. Values below 4 latch as 4.
- data_bits  in  4  data bits per frame. Latched at start and clamped to the range 5..9.
- par_en  in  1  when set, the frame includes a parity bit. Latched at start.
- stop2  in  1  when set, the frame has two stop bits. Latched at start. This port exists only when `RX_TIMER_STOP2_EN` is defined.
- start  in  1  single-cycle start-edge pulse.
- abort  in  1  synchronous frame cancel.
- busy  out  1  high while a frame is being timed.
- edge_cnt  out  PRESCALE_W  position within the current bit, counting 0..P-1.
- bit_cnt  out  BIT_CNT_W  index of the current bit within the frame. Index 0 is the start bit.
- sample_stb  out  1  majority-vote sample strobe.
- sample_last  out  1  marks the third (final) sample of the current bit.
- bit_done  out  1  last edge of the current bit.
- frame_done  out  1  last edge of the final stop bit.

## Operation
- Frame length is F = 1 + D + par_en + S, where D is the clamped data-bit count and S is 1 or 2 stop bits.
- Mid-bit point is M = P >> 1.
- State machine has two states: IDLE and RUN.
  - IDLE: counters are held at 0. When `start` is high, the block latches P, D, par_en and S, and moves to RUN.
  - RUN: `edge_cnt` increments every cycle.
  - At `edge_cnt` == P-1, `edge_cnt` wraps to 0 and `bit_cnt` increments.
  - When that wrap occurs with `bit_cnt` == F-1, the block returns to IDLE with both counters at 0.
- Strobes are a combinational decode of the registered state and counters, and are valid only in RUN:
  - `sample_stb` is high when `edge_cnt` is M-1, M or M+1.
  - `sample_last` is high when `edge_cnt` is M+1.
  - `bit_done` is high when `edge_cnt` is P-1.
  - `frame_done` is high when `bit_done` is high and `bit_cnt` is F-1.
- `busy` equals (state == RUN).
- Event priority:
  - `abort` has the highest priority. In any state it forces IDLE with counters at 0 on the next edge.
  - `start` while in RUN is ignored.
  - `start` and `abort` in the same cycle: `abort` wins and the block stays in IDLE.
- Changes to `prescale`, `data_bits`, `par_en` or `stop2` during RUN have no effect until the next start.
- Arithmetic rules:
  - Counter wrap uses the latched P only. `edge_cnt` never reaches P.
  - F is at most 13, so it always fits in BIT_CNT_W = 4.

## Timing
- Reset values: state IDLE, `edge_cnt` 0, `bit_cnt` 0. All outputs, including `busy`, read 0.
- Reset asserted mid-frame returns the block to the reset values immediately, because reset is asynchronous.
- If `start` is sampled at edge T, then:
  - `busy` is high from cycle T+1 through cycle T+F·P.
  - In cycle T+1, `edge_cnt` is 0 and `bit_cnt` is 0.
  - `frame_done` is high in cycle T+F·P.
  - In cycle T+F·P+1, the block is in IDLE.
- A new `start` is accepted in the cycle after `frame_done`. Frames can therefore be back-to-back with a one-cycle gap.
- Each bit produces exactly 3 `sample_stb` cycles, 1 `sample_last` cycle and 1 `bit_done` cycle.

## Configuration
- Macro: `RX_TIMER_STOP2_EN`.
- Defined: the `stop2` port exists, and S = 1 + stop2.
- Undefined: the `stop2` port is absent, S is fixed at 1, and the maximum F is 12.
- All other behaviour is identical in both builds.

## Test plan
- Basic frame: P=8, data_bits=8, par_en=0, stop2=0, `start` pulse.
  - `busy` is high for 80 cycles.
  - `sample_stb` is high at `edge_cnt` 3, 4 and 5 in each of the 10 bits.
  - `frame_done` is high only at `bit_cnt`=9, `edge_cnt`=7.
- Clamping: P=2, data_bits=12, par_en=1, stop2=1 (macro defined).
  - The block behaves as P=4 and F=13, so `busy` lasts 52 cycles.
  - Strobes occur at `edge_cnt` 1, 2 and 3.
- Mid-frame abort: P=16, 8N1 frame, `abort` at `bit_cnt`=4.
  - On the next cycle: IDLE, counters at 0, `busy` 0, no `frame_done`.
  - Simultaneous `start`+`abort` in IDLE: the block stays in IDLE.
- Live-change and restart: change `prescale` and `data_bits` during RUN.
  - Timing of the current frame is unchanged.
  - `start` during RUN is ignored.
  - `start` in the cycle after `frame_done` begins a new frame using the new settings.
- Async reset at `bit_cnt`=3, `edge_cnt`=5.
  - All outputs read 0 immediately.
  - After reset deasserts, `start` produces a full, correct frame.
- Build without `RX_TIMER_STOP2_EN`: P=10, data_bits=7, par_en=1.
  - F=10, `busy` lasts 100 cycles, and `frame_done` is high at `bit_cnt`=9, `edge_cnt`=9.

Source files
------------

// File: rtl/rx_bit_timer.sv
// Oversampling bit/frame timer for the UART receiver: counts prescale edges per bit
// and bits per frame after a start edge. Optional second stop bit: RX_TIMER_STOP2_EN.
module rx_bit_timer #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [3:0]            data_bits,
    input  logic                  par_en,
`ifdef RX_TIMER_STOP2_EN
    input  logic                  stop2,
`endif
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  sample_stb,
    output logic                  sample_last,
    output logic                  bit_done,
    output logic                  frame_done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_q;
    logic [PRESCALE_W-1:0] p_q;
    logic [PRESCALE_W-1:0] p_d;
    logic [BIT_CNT_W-1:0]  f_q;
    logic [BIT_CNT_W-1:0]  f_d;
    logic [PRESCALE_W-1:0] edge_q;
    logic [BIT_CNT_W-1:0]  bit_q;
    logic [3:0]            d_clamp;
    logic                  stop_extra;
    logic [PRESCALE_W-1:0] mid;
    logic                  run;

    // Frame configuration, captured only when a frame starts.
    always_comb begin
        p_d = (prescale < PRESCALE_W'(4)) ? PRESCALE_W'(4) : prescale;
        if (data_bits < 4'd5) begin
            d_clamp = 4'd5;
        end else if (data_bits > 4'd9) begin
            d_clamp = 4'd9;
        end else begin
            d_clamp = data_bits;
        end
`ifdef RX_TIMER_STOP2_EN
        stop_extra = stop2;
`else
        stop_extra = 1'b0;
`endif
        // start bit + data + parity + (1 + optional second) stop bits
        f_d = BIT_CNT_W'(2) + BIT_CNT_W'(d_clamp) + BIT_CNT_W'(par_en)
            + BIT_CNT_W'(stop_extra);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            p_q     <= PRESCALE_W'(4);
            f_q     <= '0;
            edge_q  <= '0;
            bit_q   <= '0;
        end else if (abort) begin
            state_q <= IDLE;
            edge_q  <= '0;
            bit_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    edge_q <= '0;
                    bit_q  <= '0;
                    if (start) begin
                        p_q     <= p_d;
                        f_q     <= f_d;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (edge_q == p_q - PRESCALE_W'(1)) begin
                        edge_q <= '0;
                        if (bit_q == f_q - BIT_CNT_W'(1)) begin
                            bit_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            bit_q <= bit_q + BIT_CNT_W'(1);
                        end
                    end else begin
                        edge_q <= edge_q + PRESCALE_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    edge_q  <= '0;
                    bit_q   <= '0;
                end
            endcase
        end
    end

    // P >= 4 guarantees M-1 >= 1 and M+1 <= P-1, so the three samples fit in every bit.
    assign mid         = p_q >> 1;
    assign run         = (state_q == RUN);
    assign busy        = run;
    assign edge_cnt    = edge_q;
    assign bit_cnt     = bit_q;
    assign sample_stb  = run && ((edge_q == mid - PRESCALE_W'(1)) || (edge_q == mid)
                                 || (edge_q == mid + PRESCALE_W'(1)));
    assign sample_last = run && (edge_q == mid + PRESCALE_W'(1));
    assign bit_done    = run && (edge_q == p_q - PRESCALE_W'(1));
    assign frame_done  = bit_done && (bit_q == f_q - BIT_CNT_W'(1));

endmodule
